// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//
// Shared types and constants for the pipeline hazard controller.
//
//   hcu_state_t  : controller FSM state (RUN / STALL)
//   FWD_*        : encoding of the EX operand forwarding selects
//   STALL_CNT_W  : width of the remaining-bubble counter (LOAD_STALL_CYCLES
//                  is limited to 1..15, so 4 bits always suffice)
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } hcu_state_t;

    // EX operand source select
    localparam logic [1:0] FWD_RF  = 2'b00;  // register-file value from ID_EX
    localparam logic [1:0] FWD_WB  = 2'b01;  // result being written back
    localparam logic [1:0] FWD_MEM = 2'b10;  // ALU result sitting in EX_MEM

    localparam int unsigned STALL_CNT_W = 4;

endpackage

// File: rtl/hazard_control_unit_fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
//
// Forwarding select for one EX ALU operand. Picks the youngest in-flight
// producer of the operand's source register. MEM is younger than WB, so
// a MEM match wins. Register 0 is hard-wired to zero and is never forwarded.
//
// Ports
//   src_i            in  REG_ADDR_W  source register of the EX operand
//   mem_reg_write_i  in  1           instruction in MEM writes the RF
//   mem_write_reg_i  in  REG_ADDR_W  destination register of MEM instruction
//   wb_reg_write_i   in  1           instruction in WB writes the RF
//   wb_write_reg_i   in  REG_ADDR_W  destination register of WB instruction
//   sel_o            out 2           FWD_RF / FWD_WB / FWD_MEM
// -----------------------------------------------------------------------------
module fwd_select
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic                  mem_reg_write_i,
    input  logic [REG_ADDR_W-1:0] mem_write_reg_i,
    input  logic                  wb_reg_write_i,
    input  logic [REG_ADDR_W-1:0] wb_write_reg_i,
    output logic [1:0]            sel_o
);

    logic src_nonzero;
    logic mem_hit;
    logic wb_hit;

    assign src_nonzero = (src_i != '0);
    assign mem_hit     = src_nonzero && mem_reg_write_i && (mem_write_reg_i == src_i);
    assign wb_hit      = src_nonzero && wb_reg_write_i  && (wb_write_reg_i  == src_i);

    always_comb begin
        sel_o = FWD_RF;
        if (mem_hit) begin
            sel_o = FWD_MEM;
        end else if (wb_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//
// Hazard controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
//   - Forwarding selects for both EX ALU operands (combinational).
//   - Load-use detection: inserts LOAD_STALL_CYCLES bubbles into ID_EX while
//     holding PC and IF_ID.
//   - Redirect (taken branch / J / JR resolved in MEM): flushes IF_ID, ID_EX
//     and EX_MEM in the same cycle and cancels any stall in progress.
//
// Parameters
//   REG_ADDR_W         register-index width
//   LOAD_STALL_CYCLES  bubbles per load-use hazard, 1..15
//   CNT_W              perf counter width (only with HCU_PERF_CNT_EN)
//
// Ports
//   clk, reset                     clock (rising edge), synchronous active-high reset
//   id_rs, id_rt, id_uses_rs/rt    sources of the ID instruction and whether read
//   ex_rs, ex_rt                   sources of the EX instruction
//   ex_mem_read, ex_reg_write,
//   ex_write_reg                   EX instruction is a load / writes RF / dest
//   mem_reg_write, mem_write_reg   MEM producer
//   wb_reg_write,  wb_write_reg    WB producer
//   mem_redirect                   control-flow redirect resolved in MEM
//   pc_enable, if_id_enable        PC / IF_ID load enables
//   if_id_flush, id_ex_flush,
//   ex_mem_flush                   clear the pipe register to NOP next edge
//   fwd_a_sel, fwd_b_sel           EX operand source (00 RF, 01 WB, 10 MEM)
//   stall_cycles, flush_events     saturating perf counters (HCU_PERF_CNT_EN)
//   dbg_state                      current FSM state (hcu_state_t encoding)
//
// Build option
//   HCU_PERF_CNT_EN  when defined, adds the stall_cycles / flush_events
//                    counters and their output ports.
// -----------------------------------------------------------------------------
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W        = 5,
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,

    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_write_reg,

    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_write_reg,

    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,

    input  logic                  mem_redirect,

    output logic                  pc_enable,
    output logic                  if_id_enable,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
`ifdef HCU_PERF_CNT_EN
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events,
`endif
    output logic                  dbg_state
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // -------------------------------------------------------------------------
    if ((LOAD_STALL_CYCLES < 1) || (LOAD_STALL_CYCLES > 15) || (CNT_W < 1)) begin : g_bad_param
        $error("hazard_control_unit: LOAD_STALL_CYCLES must be 1..15 and CNT_W >= 1");
    end

    // Bubbles still owed after the first one, which is issued from RUN.
    localparam logic [STALL_CNT_W-1:0] STALL_INIT = STALL_CNT_W'(LOAD_STALL_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Forwarding
    // -------------------------------------------------------------------------
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src_i           (ex_rs),
        .mem_reg_write_i (mem_reg_write),
        .mem_write_reg_i (mem_write_reg),
        .wb_reg_write_i  (wb_reg_write),
        .wb_write_reg_i  (wb_write_reg),
        .sel_o           (fwd_a_raw)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src_i           (ex_rt),
        .mem_reg_write_i (mem_reg_write),
        .mem_write_reg_i (mem_write_reg),
        .wb_reg_write_i  (wb_reg_write),
        .wb_write_reg_i  (wb_write_reg),
        .sel_o           (fwd_b_raw)
    );

    // While reset is held the pipe runs with register-file operands only.
    assign fwd_a_sel = reset ? FWD_RF : fwd_a_raw;
    assign fwd_b_sel = reset ? FWD_RF : fwd_b_raw;

    // -------------------------------------------------------------------------
    // Load-use detection
    // -------------------------------------------------------------------------
    // A load in EX produces its value only at the end of MEM, too late for an
    // ID consumer to pick it up via forwarding next cycle. $zero never stalls.
    logic load_dest_valid;
    logic rs_hit;
    logic rt_hit;
    logic load_use;

    assign load_dest_valid = ex_mem_read && ex_reg_write && (ex_write_reg != '0);
    assign rs_hit          = id_uses_rs && (id_rs == ex_write_reg);
    assign rt_hit          = id_uses_rt && (id_rt == ex_write_reg);
    assign load_use        = load_dest_valid && (rs_hit || rt_hit);

    // -------------------------------------------------------------------------
    // Controller FSM
    // -------------------------------------------------------------------------
    hcu_state_t             state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        stall_cnt_d  = stall_cnt_q;
        pc_enable    = 1'b1;
        if_id_enable = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;

        if (reset) begin
            state_d     = RUN;
            stall_cnt_d = '0;
        end else if (mem_redirect) begin
            // Everything younger than MEM is on the wrong path, including a
            // load-use consumer in ID, so the stall is simply dropped.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = RUN;
            stall_cnt_d  = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (load_use) begin
                        pc_enable    = 1'b0;
                        if_id_enable = 1'b0;
                        id_ex_flush  = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d     = STALL;
                            stall_cnt_d = STALL_INIT;
                        end
                    end
                end
                STALL: begin
                    // Inputs are ignored here: the bubble count was fixed when
                    // the hazard was first seen.
                    pc_enable    = 1'b0;
                    if_id_enable = 1'b0;
                    id_ex_flush  = 1'b1;
                    stall_cnt_d  = stall_cnt_q - STALL_CNT_W'(1);
                    if (stall_cnt_q <= STALL_CNT_W'(1)) begin
                        state_d     = RUN;
                        stall_cnt_d = '0;
                    end
                end
                default: begin
                    state_d     = RUN;
                    stall_cnt_d = '0;
                end
            endcase
        end
    end

    assign dbg_state = state_q;

    // -------------------------------------------------------------------------
    // Optional performance counters (saturating)
    // -------------------------------------------------------------------------
`ifdef HCU_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] flush_events_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (!pc_enable && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
            if (mem_redirect && (flush_events_q != '1)) begin
                flush_events_q <= flush_events_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule
